// File: rtl/debug_link_v2.sv
// Debug link between a UART byte stream and a MIPS core: instruction load,
// single step, run-to-halt and a full PC/register/memory/ALU dump.
module debug_link_v2 #(
  parameter int unsigned NB         = 32,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned N_REGS     = 32,
  parameter int unsigned N_MEM      = 16,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_uart_rx_ready,
  input  logic [DATA_BITS-1:0]          i_uart_rx_data,
  input  logic                          i_uart_tx_done,
  input  logic [NB-1:0]                 i_mips_pc,
  input  logic [NB-1:0]                 i_mips_register,
  input  logic [NB-1:0]                 i_mips_mem_data,
  input  logic [NB-1:0]                 i_mips_alu_result,
  input  logic                          i_mips_wb_halt,
  output logic                          o_uart_tx_ready,
  output logic [DATA_BITS-1:0]          o_uart_tx_data,
  output logic                          o_step,
  output logic [3:0]                    o_state_debug,
  output logic [4:0]                    o_mips_register_number,
  output logic [NB-1:0]                 o_mips_memory_address,
  output logic                          o_instruction_write_enable,
  output logic [$clog2(IMEM_DEPTH)-1:0] o_instruction_address,
  output logic [NB-1:0]                 o_instruction_data
);

  localparam int unsigned AW      = $clog2(IMEM_DEPTH);
  localparam int unsigned BYTES   = NB / DATA_BITS;
  localparam int unsigned BCW     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned N_ITEMS = 2 + N_REGS + N_MEM;
  localparam int unsigned IW      = $clog2(N_ITEMS + 1);

  localparam logic [DATA_BITS-1:0] CMD_LOAD = DATA_BITS'(8'h4C);
  localparam logic [DATA_BITS-1:0] CMD_STEP = DATA_BITS'(8'h53);
  localparam logic [DATA_BITS-1:0] CMD_RUN  = DATA_BITS'(8'h52);
  localparam logic [DATA_BITS-1:0] CMD_DUMP = DATA_BITS'(8'h44);
  localparam logic [DATA_BITS-1:0] CMD_HALT = DATA_BITS'(8'h48);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LD_CNT  = 4'd1,
    S_LD_BYTE = 4'd2,
    S_LD_WR   = 4'd3,
    S_STEP    = 4'd4,
    S_RUN     = 4'd5,
    S_D_SEL   = 4'd6,
    S_D_CAP   = 4'd7,
    S_TX_SEND = 4'd8,
    S_TX_WAIT = 4'd9
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   word_cnt_q, word_cnt_d;
  logic [DATA_BITS-1:0]   word_num_q, word_num_d;
  logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [NB-1:0]          asm_q, asm_d;
  logic [NB-1:0]          shift_q, shift_d;
  logic [IW-1:0]          item_q, item_d;
  logic                   tx_ready_q, tx_ready_d;
  logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
  logic                   we_q, we_d;
  logic [AW-1:0]          iaddr_q, iaddr_d;
  logic [NB-1:0]          idata_q, idata_d;
  logic [4:0]             reg_num_q, reg_num_d;
  logic [NB-1:0]          mem_addr_q, mem_addr_d;

  logic [NB-1:0]          asm_shift;
  logic [NB-1:0]          cap_word;
  logic                   halt_byte;

  assign halt_byte = i_uart_rx_ready && (i_uart_rx_data == CMD_HALT);
  // Incoming byte enters at the top so the first (least significant) byte ends at the bottom.
  assign asm_shift = NB'({i_uart_rx_data, asm_q} >> DATA_BITS);

  // Select the word for the dump item being captured.
  always_comb begin
    cap_word = i_mips_alu_result;
    if (item_q == '0) begin
      cap_word = i_mips_pc;
    end else if (item_q <= IW'(N_REGS)) begin
      cap_word = i_mips_register;
    end else if (item_q <= IW'(N_REGS + N_MEM)) begin
      cap_word = i_mips_mem_data;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    word_num_d = word_num_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    shift_d    = shift_q;
    item_d     = item_q;
    tx_ready_d = 1'b0;
    tx_data_d  = tx_data_q;
    we_d       = 1'b0;
    iaddr_d    = iaddr_q;
    idata_d    = idata_q;
    reg_num_d  = reg_num_q;
    mem_addr_d = mem_addr_q;

    case (state_q)
      S_IDLE: begin
        if (i_uart_rx_ready) begin
          if (i_uart_rx_data == CMD_LOAD) begin
            state_d = S_LD_CNT;
          end else if (i_uart_rx_data == CMD_STEP) begin
            state_d = S_STEP;
          end else if (i_uart_rx_data == CMD_RUN) begin
            state_d = S_RUN;
          end else if (i_uart_rx_data == CMD_DUMP) begin
            state_d    = S_D_SEL;
            item_d     = '0;
            byte_cnt_d = '0;
          end
        end
      end
      S_LD_CNT: begin
        if (i_uart_rx_ready) begin
          if (i_uart_rx_data == '0) begin
            state_d = S_IDLE;
          end else begin
            word_cnt_d = i_uart_rx_data;
            word_num_d = '0;
            byte_cnt_d = '0;
            state_d    = S_LD_BYTE;
          end
        end
      end
      S_LD_BYTE: begin
        if (i_uart_rx_ready) begin
          asm_d = asm_shift;
          if (byte_cnt_q == BCW'(BYTES - 1)) begin
            byte_cnt_d = '0;
            we_d       = 1'b1;
            idata_d    = asm_shift;
            iaddr_d    = AW'(word_num_q);
            state_d    = S_LD_WR;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      S_LD_WR: begin
        word_num_d = word_num_q + 1'b1;
        state_d    = (word_num_d == word_cnt_q) ? S_IDLE : S_LD_BYTE;
      end
      S_STEP: begin
        state_d    = S_D_SEL;
        item_d     = '0;
        byte_cnt_d = '0;
      end
      S_RUN: begin
        if (i_mips_wb_halt || halt_byte) begin
          state_d    = S_D_SEL;
          item_d     = '0;
          byte_cnt_d = '0;
        end
      end
      S_D_SEL: begin
        state_d = S_D_CAP;
      end
      S_D_CAP: begin
        shift_d    = cap_word;
        tx_data_d  = cap_word[DATA_BITS-1:0];
        tx_ready_d = 1'b1;
        byte_cnt_d = '0;
        state_d    = S_TX_SEND;
      end
      S_TX_SEND: begin
        state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (i_uart_tx_done) begin
          if (byte_cnt_q == BCW'(BYTES - 1)) begin
            byte_cnt_d = '0;
            if (item_q == IW'(N_ITEMS - 1)) begin
              state_d = S_IDLE;
            end else begin
              item_d  = item_q + 1'b1;
              state_d = S_D_SEL;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            shift_d    = shift_q >> DATA_BITS;
            tx_data_d  = shift_d[DATA_BITS-1:0];
            tx_ready_d = 1'b1;
            state_d    = S_TX_SEND;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Present the read select for the item about to be captured.
    if (state_d == S_D_SEL) begin
      if ((item_d != '0) && (item_d <= IW'(N_REGS))) begin
        reg_num_d = 5'(item_d - 1'b1);
      end else if ((item_d > IW'(N_REGS)) && (item_d <= IW'(N_REGS + N_MEM))) begin
        mem_addr_d = NB'(item_d - IW'(N_REGS + 1));
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      word_num_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      shift_q    <= '0;
      item_q     <= '0;
      tx_ready_q <= 1'b0;
      tx_data_q  <= '0;
      we_q       <= 1'b0;
      iaddr_q    <= '0;
      idata_q    <= '0;
      reg_num_q  <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      word_num_q <= word_num_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      shift_q    <= shift_d;
      item_q     <= item_d;
      tx_ready_q <= tx_ready_d;
      tx_data_q  <= tx_data_d;
      we_q       <= we_d;
      iaddr_q    <= iaddr_d;
      idata_q    <= idata_d;
      reg_num_q  <= reg_num_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Run stepping is gated by halt / stop byte in the same cycle so the halting cycle never steps.
  assign o_step = (state_q == S_STEP) ||
                  ((state_q == S_RUN) && !i_mips_wb_halt && !halt_byte);

  assign o_state_debug              = state_q;
  assign o_uart_tx_ready            = tx_ready_q;
  assign o_uart_tx_data             = tx_data_q;
  assign o_mips_register_number     = reg_num_q;
  assign o_mips_memory_address      = mem_addr_q;
  assign o_instruction_write_enable = we_q;
  assign o_instruction_address      = iaddr_q;
  assign o_instruction_data         = idata_q;

endmodule

// File: doc/debug_link_v2.md
DEBUG_LINK_V2 -- requirements
Module: debug_link_v2

Interface
REQ-001 SHALL provide parameter NB, default 32, meaning MIPS word width in bits (multiple of DATA_BITS).
REQ-002 SHALL provide parameter DATA_BITS, default 8, meaning UART byte width.
REQ-003 SHALL provide parameter N_REGS, default 32, meaning registers dumped per report (1..32).
REQ-004 SHALL provide parameter N_MEM, default 16, meaning data-memory words dumped per report (0..256).
REQ-005 SHALL provide parameter IMEM_DEPTH, default 256, meaning instruction-memory depth in words (power of two).
REQ-006 SHALL provide one clock and a reset that is asynchronous and active-low:
- i_clk  in  1  rising-edge system clock.
- i_reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL provide the UART and MIPS ports:
- i_uart_rx_ready  in  1  one-cycle strobe, byte valid.
- i_uart_rx_data  in  DATA_BITS  received byte.
- i_uart_tx_done  in  1  one-cycle strobe, byte transmitted.
- i_mips_pc  in  NB  current PC.
- i_mips_register  in  NB  register-file read data, valid 1 cycle after number changes.
- i_mips_mem_data  in  NB  data-memory read data, valid 1 cycle after address changes.
- i_mips_alu_result  in  NB  last ALU result.
- i_mips_wb_halt  in  1  halt instruction reached WB.
- o_uart_tx_ready  out  1  one-cycle start strobe to transmitter.
- o_uart_tx_data  out  DATA_BITS  byte to transmit.
- o_step  out  1  pipeline enable.
- o_state_debug  out  4  current state code.
- o_mips_register_number  out  5  register read select.
- o_mips_memory_address  out  NB  data-memory word address.
- o_instruction_write_enable  out  1  one-cycle write strobe.
- o_instruction_address  out  log2(IMEM_DEPTH)  instruction word index.
- o_instruction_data  out  NB  instruction word.

Function
REQ-008 SHALL implement states IDLE=0, LD_CNT=1, LD_BYTE=2, LD_WR=3, STEP=4, RUN=5, D_SEL=6, D_CAP=7, TX_SEND=8, TX_WAIT=9, driven on o_state_debug.
REQ-009 SHALL, in IDLE, decode each rx byte: 0x4C->LD_CNT, 0x53->STEP, 0x52->RUN, 0x44->D_SEL; any other byte ignored, remaining in IDLE.
REQ-010 SHALL take the next byte in LD_CNT as word count W; W=0 returns to IDLE with no write.
REQ-011 SHALL assemble each word from NB/DATA_BITS bytes, least-significant first, in LD_BYTE.
REQ-012 SHALL, in LD_WR, pulse o_instruction_write_enable for exactly one cycle with the assembled data and word index k (k=0..W-1, modulo IMEM_DEPTH), then return to LD_BYTE or, after word W, to IDLE.
REQ-013 SHALL, in STEP, assert o_step for exactly one cycle, then enter D_SEL.
REQ-014 SHALL, in RUN, hold o_step high each cycle until i_mips_wb_halt=1 or rx byte 0x48 arrives; o_step is low in that cycle; then enter D_SEL; if halt already high on entry, zero step cycles.
REQ-015 SHALL dump, in order: PC, registers 0..N_REGS-1, memory words 0..N_MEM-1, ALU result; total 2+N_REGS+N_MEM words.
REQ-016 SHALL, in D_SEL, drive the register number or memory address for the current item for one cycle, capture into a shift register in D_CAP, then serialize.
REQ-017 SHALL send each word as NB/DATA_BITS bytes, LSB first: TX_SEND pulses o_uart_tx_ready one cycle with o_uart_tx_data stable; TX_WAIT holds o_uart_tx_data until i_uart_tx_done.
REQ-018 SHALL return to IDLE after the final byte's i_uart_tx_done.
REQ-019 SHALL ignore rx bytes outside IDLE/LD_CNT/LD_BYTE, except 0x48 in RUN.
REQ-020 SHALL ignore i_uart_tx_done outside TX_WAIT.
REQ-021 SHALL keep o_step low in every state except STEP and RUN.

Reset
REQ-022 SHALL, on i_reset low, immediately force state IDLE and all outputs to 0, clear byte/word counters and shift register, regardless of operation in progress.
REQ-023 SHALL resume operation on the first rising edge after i_reset returns high, in IDLE.

Verification
REQ-024 Load: 0x4C,0x02, bytes 78 56 34 12 EF BE AD DE -> two write pulses: idx0=0x12345678, idx1=0xDEADBEEF; back to IDLE.
REQ-025 Step: 0x53 -> o_step high 1 cycle; 4*(34+N_MEM) bytes sent; first four = PC LSB first.
REQ-026 Run: 0x52, halt raised after 10 cycles -> o_step high exactly 10 cycles, then full dump.
REQ-027 Edge: 0x4C,0x00 -> no write, IDLE; byte 0x7F in IDLE -> ignored; 0x48 during RUN -> run stops, dump follows.
REQ-028 Reset mid-dump: i_reset low during TX_WAIT -> all outputs 0, state 0; 0x44 after release -> complete dump.
